counter_min_hour: RTL and testbench
===================================

# counter_min_hour

Minutes/hours stage of the clock datapath, directly downstream of the seconds counter. It consumes that counter's `carry_sec` output and keeps wall-clock minutes (0–59) and hours (0–23, or 1–12 with AM/PM when configured). It also supports a parallel time load for setting, and emits a one-cycle day-rollover pulse for a later calendar stage.

## Interface
Parameters:
- None. Hour mode is selected by macro (see Configuration).

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset_min`  in  1  synchronous, active-high reset.
- `carry_sec`  in  1  carry from the seconds counter; may stay high for one or more cycles per minute.
- `load_min`  in  1  level-sensitive load; while high, counting is frozen and the data inputs are captured every cycle.
- `data_min`  in  6  minute value to load.
- `data_hour`  in  5  hour value to load.
- `data_pm`  in  1  PM flag to load; ignored in 24h mode.
- `count_min`  out  6  current minute, registered.
- `count_hour`  out  5  current hour, registered.
- `pm`  out  1  PM flag, registered; constant 0 in 24h mode.
- `carry_day`  out  1  one-cycle pulse on midnight rollover, registered.

## Operation
- Edge detect: register `carry_q` samples `carry_sec` every cycle.
  - `tick = carry_sec & ~carry_q`.
  - A carry held high for N cycles produces exactly one tick.
- Priority, highest first: `reset_min`, then `load_min`, then `tick`, then hold.
- Load:
  - `count_min <= (data_min > 59) ? 59 : data_min`.
  - 24h: `count_hour <= (data_hour > 23) ? 23 : data_hour`.
  - 12h: `data_hour` of 0 or >12 saturates to 12; `pm <= data_pm`.
  - `carry_day <= 0`.
  - Ticks coinciding with load are discarded, not deferred. `carry_q` still updates during load.
- Advance (on tick, no load):
  - `count_min < 59`: `count_min + 1`.
  - `count_min == 59`: `count_min <= 0`, and the hour advances.
- Hour advance, 24h:
  - 0→…→23→0.
  - 23:59→00:00 asserts `carry_day` for one cycle.
- Hour advance, 12h:
  - 12→1, 1→…→11→12.
  - `pm` toggles on the 11→12 transition.
  - 11:59 PM→12:00 AM asserts `carry_day`.
- `carry_day` is 0 in every cycle not described above.
- Arithmetic: unsigned, no overflow possible after load saturation. Values outside range never appear on outputs.

## Timing
- Reset values:
  - `count_min = 0`, `carry_day = 0`, `carry_q = 1`.
  - 24h: `count_hour = 0`, `pm = 0`.
  - 12h: `count_hour = 12`, `pm = 0` (12:00 AM).
  - `carry_q = 1` suppresses a spurious tick if `carry_sec` is high when reset releases.
- Latency: `carry_sec` rises at edge k → counts update at edge k+1. `carry_day` is high in the same cycle the counts show midnight.
- Load latency: 1 cycle; outputs show loaded values the cycle after `load_min` is sampled high.
- Load released while `carry_sec` is high: no tick, because `carry_q` was already tracking.
- `reset_min` mid-count or mid-load: next edge produces the reset values; any pending edge is lost.
- Reset and load both high: reset wins.
- Consecutive ticks need `carry_sec` low for at least 1 cycle between them. Back-to-back ticks are legal and each advances once.

## Configuration
- Macro `COUNTER_12H_EN`.
- Defined: 12-hour mode, with hour range 1–12, the `pm` flag, 12-mode load saturation and reset value 12:00 AM.
- Undefined: 24-hour mode, hour range 0–23, `pm` tied to 0, `data_pm` unused.
- The port list is identical in both builds.

## Test plan
- Reset, then `carry_sec` high for 3 cycles → `count_min = 1` (single tick), `carry_day = 0`; `count_min` changes exactly 1 cycle after the rise.
- 24h: load 23:58, release, two carry pulses → 23:59, then 00:00 with `carry_day = 1` for exactly one cycle; all other cycles 0.
- `load_min` with `data_min = 63`, `data_hour = 30` → outputs 59/23 (24h) or 59/12 (12h); a `carry_sec` rise during load leaves the values unchanged.
- 12h build: load 11:59 PM (`data_pm = 1`), one tick → 12:00, `pm = 0`, `carry_day = 1`. Load 11:59 AM, one tick → 12:00, `pm = 1`, `carry_day = 0`.
- Hold `carry_sec = 1` through reset assertion and release → no advance after release; the count stays at its reset value until `carry_sec` falls and rises again.
- Assert `reset_min` for one cycle at 14:37 in the same cycle as a carry rise → next cycle shows the reset values and no advance.

Source files
------------

// File: rtl/counter_min_hour.sv
// counter_min_hour: minutes/hours stage of the clock datapath.
// Counts minutes 0-59 and hours from the seconds carry, supports a
// level-sensitive parallel load, and pulses carry_day at midnight.
// Build option: define COUNTER_12H_EN for 12-hour mode (hours 1-12 with
// a pm flag, reset to 12:00 AM). Undefined gives 24-hour mode (hours
// 0-23, pm tied low, data_pm unused). The port list is the same either way.
module counter_min_hour (
  input  logic       clock,
  input  logic       reset_min,
  input  logic       carry_sec,
  input  logic       load_min,
  input  logic [5:0] data_min,
  input  logic [4:0] data_hour,
  input  logic       data_pm,
  output logic [5:0] count_min,
  output logic [4:0] count_hour,
  output logic       pm,
  output logic       carry_day
);

  localparam logic [5:0] MIN_LAST  = 6'd59;
`ifdef COUNTER_12H_EN
  localparam logic [4:0] HOUR_RST  = 5'd12;
  localparam logic [4:0] HOUR_LAST = 5'd12;
`else
  localparam logic [4:0] HOUR_RST  = 5'd0;
  localparam logic [4:0] HOUR_LAST = 5'd23;
`endif

  logic       carry_q,  carry_d;
  logic [5:0] min_q,    min_d;
  logic [4:0] hour_q,   hour_d;
  logic       pm_q,     pm_d;
  logic       day_q,    day_d;
  logic       tick;

`ifndef COUNTER_12H_EN
  // The pm input has no meaning in 24-hour mode.
  logic unused_data_pm;
  assign unused_data_pm = data_pm;
`endif

  // A carry held high for several cycles yields exactly one tick.
  assign tick = carry_sec & ~carry_q;

  // Next-state: load beats tick, tick advances minutes and rolls hours.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    carry_d = carry_sec;
    min_d   = min_q;
    hour_d  = hour_q;
    pm_d    = pm_q;
    day_d   = 1'b0;

    if (load_min) begin
      // Ticks arriving during a load are dropped; carry_q still tracks.
      min_d = (data_min > MIN_LAST) ? MIN_LAST : data_min;
`ifdef COUNTER_12H_EN
      hour_d = (data_hour == 5'd0 || data_hour > HOUR_LAST) ? HOUR_LAST : data_hour;
      pm_d   = data_pm;
`else
      hour_d = (data_hour > HOUR_LAST) ? HOUR_LAST : data_hour;
      pm_d   = 1'b0;
`endif
    end else if (tick) begin
      if (min_q != MIN_LAST) begin
        min_d = min_q + 6'd1;
      end else begin
        min_d = 6'd0;
`ifdef COUNTER_12H_EN
        // 12 wraps to 1; crossing 11 -> 12 flips AM/PM, and PM -> AM is midnight.
        hour_d = (hour_q == HOUR_LAST) ? 5'd1 : hour_q + 5'd1;
        if (hour_q == 5'd11) begin
          pm_d  = ~pm_q;
          day_d = pm_q;
        end
`else
        if (hour_q == HOUR_LAST) begin
          hour_d = 5'd0;
          day_d  = 1'b1;
        end else begin
          hour_d = hour_q + 5'd1;
        end
`endif
      end
    end
  end

  // State register with synchronous reset; carry_q resets high so a carry
  // already asserted at reset release does not count as a rising edge.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values seen before the edge.
    if (reset_min) begin
      carry_q <= 1'b1;
      min_q   <= 6'd0;
      hour_q  <= HOUR_RST;
      pm_q    <= 1'b0;
      day_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      pm_q    <= pm_d;
      day_q   <= day_d;
    end
  end

  assign count_min  = min_q;
  assign count_hour = hour_q;
  assign pm         = pm_q;
  assign carry_day  = day_q;

endmodule

// File: tb/tb_counter_min_hour.sv
// Self-checking bench for counter_min_hour. A reference model tracks time
// as minutes-of-day; expected outputs are queued as each cycle's stimulus
// is driven and popped after the edge for comparison.
module tb_counter_min_hour;

  logic       clock;
  logic       reset_min;
  logic       carry_sec;
  logic       load_min;
  logic [5:0] data_min;
  logic [4:0] data_hour;
  logic       data_pm;
  logic [5:0] count_min;
  logic [4:0] count_hour;
  logic       pm;
  logic       carry_day;

  counter_min_hour dut (
    .clock      (clock),
    .reset_min  (reset_min),
    .carry_sec  (carry_sec),
    .load_min   (load_min),
    .data_min   (data_min),
    .data_hour  (data_hour),
    .data_pm    (data_pm),
    .count_min  (count_min),
    .count_hour (count_hour),
    .pm         (pm),
    .carry_day  (carry_day)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int m;
    int h;
    int p;
    int d;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state.
  int   m_mins  = 0;
  bit   m_carry = 1'b1;
  bit   m_day   = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Drive one cycle, update the model, queue the expectation, then compare
  // DUT outputs just after the rising edge.
  task automatic step(input bit r, input bit c, input bit l,
                      input logic [5:0] dm, input logic [4:0] dh, input bit dp);
    bit   tk;
    int   msat, hsat, h24;
    exp_t e, got;
    reset_min = r;
    carry_sec = c;
    load_min  = l;
    data_min  = dm;
    data_hour = dh;
    data_pm   = dp;

    tk = c & ~m_carry;
    if (r) begin
      m_mins  = 0;
      m_day   = 1'b0;
      m_carry = 1'b1;
    end else begin
      if (l) begin
        msat = (int'(dm) > 59) ? 59 : int'(dm);
`ifdef COUNTER_12H_EN
        hsat = (dh == 0 || int'(dh) > 12) ? 12 : int'(dh);
        h24  = (hsat % 12) + (dp ? 12 : 0);
`else
        hsat = (int'(dh) > 23) ? 23 : int'(dh);
        h24  = hsat;
`endif
        m_mins = h24 * 60 + msat;
        m_day  = 1'b0;
      end else if (tk) begin
        m_mins = m_mins + 1;
        m_day  = 1'b0;
        if (m_mins == 1440) begin
          m_mins = 0;
          m_day  = 1'b1;
        end
      end else begin
        m_day = 1'b0;
      end
      m_carry = c;
    end

    h24 = m_mins / 60;
    e.m = m_mins % 60;
`ifdef COUNTER_12H_EN
    e.h = (h24 % 12 == 0) ? 12 : h24 % 12;
    e.p = (h24 >= 12) ? 1 : 0;
`else
    e.h = h24;
    e.p = 0;
`endif
    e.d = m_day ? 1 : 0;
    sb_q.push_back(e);

    @(posedge clock);
    #1;
    got = sb_q.pop_front();
    check("min",  int'(count_min),  got.m);
    check("hour", int'(count_hour), got.h);
    check("pm",   int'(pm),         got.p);
    check("day",  int'(carry_day),  got.d);
  endtask

  task automatic idle(input bit c);
    step(1'b0, c, 1'b0, 6'd0, 5'd0, 1'b0);
  endtask

  // Load a time given in 24-hour terms, encoded for the build's hour mode.
  task automatic load_time(input int h24, input int m, input bit c);
    logic [4:0] dh;
    bit         dp;
`ifdef COUNTER_12H_EN
    dh = 5'((h24 % 12 == 0) ? 12 : h24 % 12);
    dp = (h24 >= 12);
`else
    dh = 5'(h24);
    dp = 1'($urandom_range(0, 1));
`endif
    step(1'b0, c, 1'b1, 6'(m), dh, dp);
  endtask

  task automatic pulse();
    idle(1'b1);
    idle(1'b0);
  endtask

  initial begin
    reset_min = 1'b1;
    carry_sec = 1'b0;
    load_min  = 1'b0;
    data_min  = '0;
    data_hour = '0;
    data_pm   = 1'b0;

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0);
    check("rst_min", int'(count_min), 0);
    check("rst_day", int'(carry_day), 0);

    // Carry held for 3 cycles produces a single tick, visible right after the rise.
    idle(1'b0);
    idle(1'b1);
    check("hold_rise_min", int'(count_min), 1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    check("hold_min", int'(count_min), 1);

    // 23:58 -> 23:59 -> 00:00 with a one-cycle day pulse.
    load_time(23, 58, 1'b0);
    idle(1'b0);
    pulse();
    check("2359_min", int'(count_min), 59);
    idle(1'b1);
    check("midnight_day", int'(carry_day), 1);
    idle(1'b0);
    check("midnight_day_clr", int'(carry_day), 0);
    idle(1'b0);

    // Out-of-range load saturates; carry rising during load is discarded.
    step(1'b0, 1'b0, 1'b1, 6'd63, 5'd30, 1'b0);
    check("sat_min", int'(count_min), 59);
    step(1'b0, 1'b1, 1'b1, 6'd63, 5'd30, 1'b0);
    step(1'b0, 1'b1, 1'b1, 6'd63, 5'd30, 1'b0);
    idle(1'b1);   // load released with carry high: no tick
    check("release_min", int'(count_min), 59);
    idle(1'b0);
    idle(1'b1);   // genuine rise: 59 -> 0 and hour advance
    idle(1'b0);

    // 11:59 PM -> midnight, 11:59 AM -> noon.
    load_time(23, 59, 1'b0);
    idle(1'b1);
    check("pm_midnight_day", int'(carry_day), 1);
    idle(1'b0);
    load_time(11, 59, 1'b0);
    idle(1'b1);
    check("noon_day", int'(carry_day), 0);
    idle(1'b0);

    // Carry held high through reset assertion and release: no advance.
    load_time(5, 10, 1'b0);
    idle(1'b1);
    step(1'b1, 1'b1, 1'b0, 6'd0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 6'd0, 5'd0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("rst_held_min", int'(count_min), 0);
    idle(1'b0);
    idle(1'b1);
    check("rst_held_adv", int'(count_min), 1);
    idle(1'b0);

    // Reset coinciding with a carry rise at 14:37.
    load_time(14, 37, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b1, 1'b0, 6'd0, 5'd0, 1'b0);
    check("rst_rise_min", int'(count_min), 0);
    idle(1'b0);

    // Reset and load together: reset wins.
    step(1'b1, 1'b0, 1'b1, 6'd20, 5'd7, 1'b1);
    idle(1'b0);

    // Back-to-back ticks across an hour boundary.
    load_time(9, 57, 1'b0);
    for (int i = 0; i < 6; i++) pulse();

    // Randomised stretch.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 24) == 0),
           6'($urandom_range(0, 63)),
           5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
